// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and sizes for the two-requester Gray-code conversion arbiter.
// Holds the output-slot state encoding, operand width and requester count.
package gray_conv_arbiter_pkg;

  localparam int DATA_W  = 4;
  localparam int NUM_REQ = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/gray_conv_arbiter_bin2gray4.sv
// Purely combinational 4-bit binary to reflected-Gray converter.
// Zero latency; no flow control of its own.
module bin2gray4
  import gray_conv_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0] bin_i,
  output logic [DATA_W-1:0] gray_o
);

  assign gray_o[3] = bin_i[3];
  assign gray_o[2] = bin_i[3] ^ bin_i[2];
  assign gray_o[1] = bin_i[2] ^ bin_i[1];
  assign gray_o[0] = bin_i[1] ^ bin_i[0];

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter feeding one registered Gray-code result slot; 1-cycle latency.
// A request is granted only when the slot is empty or being drained in the same cycle.
module gray_conv_arbiter
  import gray_conv_arbiter_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [DATA_W-1:0]    req_bin0,
  input  logic [DATA_W-1:0]    req_bin1,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_gray,
  output logic                 out_id,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  state_e             state_q;
  logic               ptr_q;
  logic [DATA_W-1:0]  gray_q;
  logic               id_q;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;

  logic               slot_free;
  logic               consume;
  logic               take;
  logic               win_id;
  logic [NUM_REQ-1:0] grant;
  logic [DATA_W-1:0]  win_bin;
  logic [DATA_W-1:0]  win_gray;

  // Grant is built from valids and pointer only, so req_ready never sees operand data.
  always_comb begin
    grant = '0;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  assign slot_free = (state_q == EMPTY) || out_ready;
  assign req_ready = (slot_free && !rst) ? grant : '0;
  assign take      = |req_ready;
  assign win_id    = req_ready[1];
  assign consume   = (state_q == FULL) && out_ready;
  assign win_bin   = win_id ? req_bin1 : req_bin0;

  bin2gray4 u_conv (
    .bin_i  (win_bin),
    .gray_o (win_gray)
  );

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (consume && !id_q && (cnt0_q != '1)) cnt0_d = cnt0_q + 1'b1;
    if (consume &&  id_q && (cnt1_q != '1)) cnt1_d = cnt1_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= 1'b0;
      gray_q  <= '0;
      id_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      case (state_q)
        EMPTY: begin
          if (take) begin
            state_q <= FULL;
            gray_q  <= win_gray;
            id_q    <= win_id;
            ptr_q   <= ~win_id;
          end
        end
        FULL: begin
          // Drain and refill in the same cycle keeps the slot full with no bubble.
          if (take) begin
            gray_q <= win_gray;
            id_q   <= win_id;
            ptr_q  <= ~win_id;
          end else if (out_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_gray  = gray_q;
  assign out_id    = id_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench: stimulus predicts grants and pushes expected results; a monitor pops on consumption.
module tb_gray_conv_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [3:0] req_bin0, req_bin1;
  logic [1:0] req_ready;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_gray;
  logic       out_id;
  logic [7:0] cnt0, cnt1;

  logic [1:0] r2_valid;
  logic [3:0] r2_bin0, r2_bin1;
  logic [1:0] r2_ready;
  logic       o2_valid, o2_ready, o2_id;
  logic [3:0] o2_gray;
  logic [1:0] c2_0, c2_1;

  int total = 0;
  int bad   = 0;

  logic [4:0] q[$];
  int  exp_cnt0 = 0;
  int  exp_cnt1 = 0;
  logic m_full = 1'b0;
  logic m_ptr  = 1'b0;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_bin0(req_bin0), .req_bin1(req_bin1),
    .req_ready(req_ready), .out_valid(out_valid), .out_ready(out_ready), .out_gray(out_gray),
    .out_id(out_id), .cnt0(cnt0), .cnt1(cnt1)
  );

  gray_conv_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(r2_valid), .req_bin0(r2_bin0), .req_bin1(r2_bin1),
    .req_ready(r2_ready), .out_valid(o2_valid), .out_ready(o2_ready), .out_gray(o2_gray),
    .out_id(o2_id), .cnt0(c2_0), .cnt1(c2_1)
  );

  function automatic logic [3:0] gray_of(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at posedge+1, predict grant from arbitration rules, push expected result.
  task automatic cycle(input logic [1:0] v, input logic [3:0] b0, input logic [3:0] b1,
                       input logic ordy);
    logic [1:0] er;
    logic       win;
    @(posedge clk); #1;
    req_valid = v; req_bin0 = b0; req_bin1 = b1; out_ready = ordy;
    #1;
    chk("out_valid", out_valid, m_full);
    er = 2'b00;
    if (!m_full || ordy) begin
      if (v == 2'b11) er = m_ptr ? 2'b10 : 2'b01;
      else            er = v;
    end
    chk("req_ready", req_ready, er);
    if (er != 2'b00) begin
      win = er[1];
      q.push_back({gray_of(win ? b1 : b0), win});
      m_ptr  = ~win;
      m_full = 1'b1;
    end else if (ordy) begin
      m_full = 1'b0;
    end
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_out_gray", out_gray, 0);
    q.delete();
    exp_cnt0 = 0; exp_cnt1 = 0; m_full = 1'b0; m_ptr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: counters checked against consumptions seen so far, then pop on handshake.
  initial begin
    logic [4:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("cnt0", cnt0, exp_cnt0);
        chk("cnt1", cnt1, exp_cnt1);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL out_unexpected: got gray %0h id %0d expected no output", out_gray, out_id);
          end else begin
            e = q.pop_front();
            chk("out_gray", out_gray, e[4:1]);
            chk("out_id", out_id, e[0]);
            if (e[0]) exp_cnt1 = (exp_cnt1 < 255) ? exp_cnt1 + 1 : 255;
            else      exp_cnt0 = (exp_cnt0 < 255) ? exp_cnt0 + 1 : 255;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int consumed;
    rst = 1'b1; req_valid = 2'b11; req_bin0 = 4'h0; req_bin1 = 4'h0; out_ready = 1'b1;
    r2_valid = 2'b00; r2_bin0 = 4'h0; r2_bin1 = 4'h0; o2_ready = 1'b0;
    #3;
    chk("init_req_ready", req_ready, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_out_gray", out_gray, 0);
    chk("init_out_id", out_id, 0);
    chk("init_cnt0", cnt0, 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    rst = 1'b0;

    // Single requester 0, then drain.
    cycle(2'b01, 4'b1000, 4'b0000, 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);
    chk("first_cnt0", cnt0, 1);

    // Both requesting: strict alternation, one result per cycle.
    repeat (4) cycle(2'b11, 4'b1011, 4'b1100, 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);

    // Backpressure with requests pending, then back-to-back replace, then drain.
    cycle(2'b01, 4'b1000, 4'b0000, 1'b1);
    repeat (3) begin
      cycle(2'b11, 4'b0110, 4'b1001, 1'b0);
      chk("hold_gray", out_gray, 4'b1100);
      chk("hold_id", out_id, 0);
    end
    cycle(2'b10, 4'b0000, 4'b0011, 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);

    // Reset while FULL; first grant afterwards goes to requester 0.
    cycle(2'b10, 4'b0000, 4'b1111, 1'b1);
    cycle(2'b10, 4'b0000, 4'b0111, 1'b0);
    reset_mid();
    cycle(2'b11, 4'b0101, 4'b1010, 1'b1);
    chk("post_rst_grant", req_ready, 2'b01);

    // Sweep all operands on requester 1.
    for (int i = 0; i < 16; i++) cycle(2'b10, 4'h0, 4'(i), 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);
    cycle(2'b00, 4'b0000, 4'b0000, 1'b1);
    chk("sweep_cnt1", cnt1, 16);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0));
    repeat (3) cycle(2'b00, 4'b0000, 4'b0000, 1'b1);
    chk("queue_drained", q.size(), 0);

    // Narrow counter instance saturates at 3.
    consumed = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      r2_valid = 2'b01; r2_bin0 = 4'(i); o2_ready = 1'b1;
      #1;
      if (o2_valid) consumed++;
    end
    repeat (3) begin
      @(posedge clk); #1;
      r2_valid = 2'b00;
      #1;
      if (o2_valid) consumed++;
    end
    chk("sat_consumed", consumed, 5);
    chk("sat_cnt0", c2_0, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_conv_arbiter.md
GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

Interface
REQ-001 The block SHALL have this parameter: CNT_W, default 8, width of the per-requester conversion counters.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port req_valid, input, 2, one conversion-request flag per requester (index 0, 1).
REQ-005 The block SHALL have port req_bin0, input, 4, binary operand from requester 0.
REQ-006 The block SHALL have port req_bin1, input, 4, binary operand from requester 1.
REQ-007 The block SHALL have port req_ready, output, 2, per-requester acceptance; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 The block SHALL have port out_valid, output, 1, result held in the output register.
REQ-009 The block SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 The block SHALL have port out_gray, output, 4, Gray-coded result.
REQ-011 The block SHALL have port out_id, output, 1, index of the requester that owns out_gray.
REQ-012 The block SHALL have port cnt0, output, CNT_W, completed conversions for requester 0.
REQ-013 The block SHALL have port cnt1, output, CNT_W, completed conversions for requester 1.

Function
REQ-014 Conversion SHALL be: gray[3]=bin[3]; gray[2]=bin[3]^bin[2]; gray[1]=bin[2]^bin[1]; gray[0]=bin[1]^bin[0].
REQ-015 The FSM SHALL have two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 The slot SHALL be free when state==EMPTY, or when state==FULL and out_ready=1.
REQ-017 When the slot is free, req_ready SHALL be one-hot to the round-robin winner among the asserted req_valid bits; otherwise req_ready SHALL be 2'b00.
REQ-018 req_ready SHALL depend combinationally on req_valid, out_ready, state and the priority pointer only, never on req_bin0 or req_bin1.
REQ-019 Round-robin: the priority pointer SHALL name the preferred requester; after each accepted transfer it SHALL move to the other index.
REQ-020 A single active requester SHALL always win, regardless of the pointer.
REQ-021 Latency: on an accepted transfer, out_gray, out_id and out_valid=1 SHALL be registered at the next clock edge (1 cycle).
REQ-022 In FULL with out_ready=0, out_gray, out_id and out_valid SHALL hold stable, and no request SHALL be accepted.
REQ-023 In FULL with out_ready=1 and an accepted request, the new result SHALL replace the old one with no bubble (throughput 1 per cycle).
REQ-024 In FULL with out_ready=1 and no accepted request, the FSM SHALL go to EMPTY.
REQ-025 cnt0/cnt1 SHALL increment when a result with out_id 0/1 is consumed (out_valid & out_ready).
REQ-026 Counters SHALL saturate at all-ones and not wrap.
REQ-027 req_valid=2'b00 SHALL cause no state change other than output drain.

Reset
REQ-028 Asserting rst SHALL asynchronously force: state EMPTY; out_valid=0; out_gray=4'b0000; out_id=0; pointer=0; cnt0=cnt1=0.
REQ-029 While rst is high, req_ready SHALL be 2'b00.
REQ-030 A result pending at reset SHALL be discarded and not counted.

Structure
REQ-031 A shared package SHALL hold the state encoding (EMPTY, FULL), the data width constant (4) and the requester count (2).
REQ-032 Conversion SHALL live in one combinational sub-module bin2gray4, instanced once on the muxed winning operand.

Verification
REQ-033 After reset, req_valid=01, req_bin0=4'b1000, out_ready=1 -> next cycle out_gray=4'b1100, out_id=0; cnt0=1 one cycle after consumption.
REQ-034 req_valid=11 held 4 cycles with req_bin0=4'b1011, req_bin1=4'b1100, out_ready=1 -> results 1110/0, 1010/1, 1110/0, 1010/1 on consecutive cycles.
REQ-035 Backpressure: FULL holding 4'b1100 with out_ready=0 for 3 cycles -> out_gray stable and req_ready=00; out_ready=1 -> drain, or back-to-back replace if a request is pending.
REQ-036 Exhaustive sweep of all 16 binary values on requester 1 -> each out_gray matches REQ-014; cnt1=16.
REQ-037 Assert rst mid-FULL between edges -> out_valid=0 immediately; counters and pointer zero; the first grant after release goes to requester 0.
REQ-038 With CNT_W=2, consume 5 results from requester 0 -> cnt0 stays at 3.
